// File: rtl/board_responder.sv
// Battleship target-side responder: owns one N x N board, answers PLACE and SHOT
// requests with a 2-bit result code, and tracks ships still afloat.
module board_responder #(
    parameter int unsigned N         = 5,
    parameter int unsigned MAX_SHIPS = 5,
    parameter int unsigned CW        = $clog2(N),
    parameter int unsigned SW        = $clog2(MAX_SHIPS + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clear,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic          i_req_op,
    input  logic [CW-1:0] i_req_x,
    input  logic [CW-1:0] i_req_y,
    output logic          o_rsp_valid,
    input  logic          i_rsp_ready,
    output logic [1:0]    o_rsp_result,
    output logic [SW-1:0] o_ships_left,
    output logic          o_all_sunk,
    output logic          o_busy
);

    localparam int unsigned CELLS = N * N;
    localparam int unsigned AW    = $clog2(CELLS);

    localparam logic [AW-1:0] LAST_IDX = AW'(CELLS - 1);
    localparam logic [SW-1:0] MAX_CNT  = SW'(MAX_SHIPS);

    localparam logic [2:0] ST_CLEAR  = 3'd0;
    localparam logic [2:0] ST_IDLE   = 3'd1;
    localparam logic [2:0] ST_LOOKUP = 3'd2;
    localparam logic [2:0] ST_UPDATE = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    localparam logic [1:0] CELL_EMPTY  = 2'd0;
    localparam logic [1:0] CELL_SHIP   = 2'd1;
    localparam logic [1:0] CELL_MISSED = 2'd2;
    localparam logic [1:0] CELL_STRUCK = 2'd3;

    // OK/MISS share 00, OCCUPIED/REPEAT share 10.
    localparam logic [1:0] RES_OK      = 2'b00;
    localparam logic [1:0] RES_HIT     = 2'b01;
    localparam logic [1:0] RES_TAKEN   = 2'b10;
    localparam logic [1:0] RES_INVALID = 2'b11;

    localparam logic OP_SHOT = 1'b1;

    logic [1:0]    r_board [CELLS];
    logic [2:0]    r_state;
    logic [AW-1:0] r_idx;
    logic          r_op;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic [AW-1:0] r_addr;
    logic [1:0]    r_cell;
    logic          r_oor;
    logic          r_rsp_valid;
    logic [1:0]    r_rsp_result;
    logic [SW-1:0] r_ships_placed;
    logic [SW-1:0] r_ships_left;
    logic          r_locked;
    logic          r_all_sunk;

    logic          w_restart;
    logic          w_in_range;
    logic [AW-1:0] w_addr;
    logic [1:0]    w_result;
    logic          w_wr_en;
    logic [1:0]    w_wr_val;
    logic [SW-1:0] w_placed_d;
    logic [SW-1:0] w_left_d;
    logic          w_locked_d;

    assign w_restart  = i_rst || i_clear;
    assign w_in_range = (32'(r_x) < N) && (32'(r_y) < N);
    assign w_addr     = AW'(r_y) * AW'(N) + AW'(r_x);

    assign o_req_ready  = (r_state == ST_IDLE);
    assign o_busy       = (r_state == ST_CLEAR);
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_result = r_rsp_result;
    assign o_ships_left = r_ships_left;
    assign o_all_sunk   = r_all_sunk;

    // Decide result, cell write and counter updates from the looked-up cell.
    always_comb begin
        w_result   = RES_INVALID;
        w_wr_en    = 1'b0;
        w_wr_val   = CELL_EMPTY;
        w_placed_d = r_ships_placed;
        w_left_d   = r_ships_left;
        w_locked_d = r_locked;
        if (r_op == OP_SHOT) begin
            if (!r_oor && (r_ships_placed != '0)) begin
                w_locked_d = 1'b1;
                unique case (r_cell)
                    CELL_EMPTY: begin
                        w_result = RES_OK;
                        w_wr_en  = 1'b1;
                        w_wr_val = CELL_MISSED;
                    end
                    CELL_SHIP: begin
                        w_result = RES_HIT;
                        w_wr_en  = 1'b1;
                        w_wr_val = CELL_STRUCK;
                        w_left_d = r_ships_left - 1'b1;
                    end
                    default: w_result = RES_TAKEN;
                endcase
            end
        end else begin
            if (r_oor || r_locked || (r_ships_placed == MAX_CNT)) begin
                w_result = RES_INVALID;
            end else if (r_cell != CELL_EMPTY) begin
                w_result = RES_TAKEN;
            end else begin
                w_result   = RES_OK;
                w_wr_en    = 1'b1;
                w_wr_val   = CELL_SHIP;
                w_placed_d = r_ships_placed + 1'b1;
                w_left_d   = r_ships_left + 1'b1;
            end
        end
    end

    // Board storage: sweep-clear one cell per cycle, otherwise the single UPDATE write.
    always_ff @(posedge i_clk) begin
        if (r_state == ST_CLEAR) begin
            r_board[r_idx] <= CELL_EMPTY;
        end else if (!w_restart && (r_state == ST_UPDATE) && w_wr_en) begin
            r_board[r_addr] <= w_wr_val;
        end
    end

    // Control FSM and counters; rst/clear restart the game from any state.
    always_ff @(posedge i_clk) begin
        if (w_restart) begin
            r_state        <= ST_CLEAR;
            r_idx          <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_result   <= 2'b00;
            r_ships_placed <= '0;
            r_ships_left   <= '0;
            r_locked       <= 1'b0;
            r_all_sunk     <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_idx == LAST_IDX) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (i_req_valid) begin
                        r_op    <= i_req_op;
                        r_x     <= i_req_x;
                        r_y     <= i_req_y;
                        r_state <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    // Out-of-range coordinates never index the board.
                    r_cell  <= w_in_range ? r_board[w_addr] : CELL_EMPTY;
                    r_oor   <= !w_in_range;
                    r_addr  <= w_addr;
                    r_state <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    r_rsp_valid    <= 1'b1;
                    r_rsp_result   <= w_result;
                    r_ships_placed <= w_placed_d;
                    r_ships_left   <= w_left_d;
                    r_locked       <= w_locked_d;
                    r_all_sunk     <= (w_placed_d != '0) && (w_left_d == '0);
                    r_state        <= ST_RESP;
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_idx   <= '0;
                end
            endcase
        end
    end

endmodule
